// File: rtl/hex_cmd_parser.sv
// hex_cmd_parser: ASCII hex "W"/"R" command lines to register-bus strobes.
// Define HEX_CMD_TIMEOUT_EN to drop stale partial commands after TIMEOUT_CYC.
module hex_cmd_parser #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 12_000_000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              bus_we,
  output logic              bus_re,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              rsp_valid,
  output logic [7:0]        rsp_data,
  input  logic              rsp_ready,
  output logic              cmd_err
);
  localparam int DD = DATA_W / 4;
  localparam logic [7:0] A_LAST = 8'(ADDR_W / 4 - 1);
  localparam logic [7:0] D_LAST = 8'(DD - 1);
  localparam logic [7:0] R_LAST = 8'(DD + 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, DATA, EOL, SKIP, EXEC, RDW, RSP
  } state_t;
  typedef enum logic [1:0] {
    RK_OK, RK_ERR, RK_DAT
  } rsp_t;

  state_t state_q, state_d;
  rsp_t kind_q, kind_d;
  logic op_wr_q, op_wr_d;
  logic [7:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_sr_q, addr_sr_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] data_sr_q, data_sr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic bus_we_q, bus_we_d;
  logic bus_re_q, bus_re_d;
  logic cmd_err_q, cmd_err_d;

  logic byte_v, is_cr, is_hex;
  logic [3:0] nib, rnib;
  logic [7:0] last;

`ifdef HEX_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] tmo_q, tmo_d;
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYC;
`endif

  // LF is invisible to every state, so it never counts as a byte
  assign byte_v = rx_valid && (rx_data != 8'h0A);
  assign is_cr  = (rx_data == 8'h0D);

  always_comb begin
    is_hex = 1'b1;
    nib    = 4'h0;
    unique case (1'b1)
      (rx_data inside {[8'h30:8'h39]}):
        nib = rx_data[3:0];
      (rx_data inside {[8'h41:8'h46]}),
      (rx_data inside {[8'h61:8'h66]}):
        nib = rx_data[3:0] + 4'd9;
      default: is_hex = 1'b0;
    endcase
  end

  always_comb begin
    last = (kind_q == RK_DAT) ? R_LAST : 8'd2;
    rnib = 4'h0;
    for (int i = 0; i < DD; i++) begin
      if (cnt_q == 8'(i))
        rnib = rdata_q[DATA_W-1-4*i -: 4];
    end
    rsp_data = 8'h00;
    if (state_q == RSP) begin
      if (cnt_q == last)
        rsp_data = 8'h0A;
      else if (cnt_q == last - 8'd1)
        rsp_data = 8'h0D;
      else if (kind_q == RK_OK)
        rsp_data = 8'h4B;
      else if (kind_q == RK_ERR)
        rsp_data = 8'h3F;
      else if (rnib < 4'd10)
        rsp_data = 8'h30 + {4'h0, rnib};
      else
        rsp_data = 8'h37 + {4'h0, rnib};
    end
  end

  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    op_wr_d     = op_wr_q;
    cnt_d       = cnt_q;
    addr_sr_d   = addr_sr_q;
    data_sr_d   = data_sr_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    bus_we_d    = 1'b0;
    bus_re_d    = 1'b0;
    cmd_err_d   = 1'b0;
    unique case (state_q)
      IDLE: if (byte_v) begin
        cnt_d = '0;
        unique case (1'b1)
          (rx_data == 8'h57 || rx_data == 8'h77): begin
            op_wr_d = 1'b1;
            state_d = ADDR;
          end
          (rx_data == 8'h52 || rx_data == 8'h72): begin
            op_wr_d = 1'b0;
            state_d = ADDR;
          end
          is_cr: ;
          default: begin
            state_d   = SKIP;
            cmd_err_d = 1'b1;
          end
        endcase
      end
      ADDR: if (byte_v) begin
        unique case (1'b1)
          is_hex: begin
            addr_sr_d = ADDR_W'({addr_sr_q, nib});
            cnt_d     = cnt_q + 8'd1;
            if (cnt_q == A_LAST) begin
              cnt_d   = '0;
              state_d = op_wr_q ? DATA : EOL;
            end
          end
          is_cr: begin
            state_d   = RSP;
            kind_d    = RK_ERR;
            cnt_d     = '0;
            cmd_err_d = 1'b1;
          end
          default: begin
            state_d   = SKIP;
            cmd_err_d = 1'b1;
          end
        endcase
      end
      DATA: if (byte_v) begin
        unique case (1'b1)
          is_hex: begin
            data_sr_d = DATA_W'({data_sr_q, nib});
            cnt_d     = cnt_q + 8'd1;
            if (cnt_q == D_LAST) begin
              cnt_d   = '0;
              state_d = EOL;
            end
          end
          is_cr: begin
            state_d   = RSP;
            kind_d    = RK_ERR;
            cnt_d     = '0;
            cmd_err_d = 1'b1;
          end
          default: begin
            state_d   = SKIP;
            cmd_err_d = 1'b1;
          end
        endcase
      end
      EOL: if (byte_v) begin
        if (is_cr) begin
          state_d    = EXEC;
          bus_addr_d = addr_sr_q;
          if (op_wr_q) begin
            bus_wdata_d = data_sr_q;
            bus_we_d    = 1'b1;
          end else begin
            bus_re_d = 1'b1;
          end
        end else begin
          state_d   = SKIP;
          cmd_err_d = 1'b1;
        end
      end
      SKIP: if (byte_v && is_cr) begin
        state_d = RSP;
        kind_d  = RK_ERR;
        cnt_d   = '0;
      end
      EXEC: begin
        cmd_err_d = byte_v;
        cnt_d     = '0;
        kind_d    = op_wr_q ? RK_OK : RK_DAT;
        state_d   = op_wr_q ? RSP : RDW;
      end
      RDW: begin
        cmd_err_d = byte_v;
        rdata_d   = bus_rdata;
        state_d   = RSP;
      end
      RSP: begin
        cmd_err_d = byte_v;
        if (rsp_ready) begin
          if (cnt_q == last)
            state_d = IDLE;
          else
            cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef HEX_CMD_TIMEOUT_EN
    tmo_d = '0;
    if (!rx_valid &&
        state_q inside {ADDR, DATA, EOL, SKIP}) begin
      if (tmo_q == T_LAST) begin
        state_d   = IDLE;
        cmd_err_d = 1'b1;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      kind_q      <= RK_OK;
      op_wr_q     <= 1'b0;
      cnt_q       <= '0;
      addr_sr_q   <= '0;
      data_sr_q   <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
      bus_we_q    <= 1'b0;
      bus_re_q    <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      op_wr_q     <= op_wr_d;
      cnt_q       <= cnt_d;
      addr_sr_q   <= addr_sr_d;
      data_sr_q   <= data_sr_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
      bus_we_q    <= bus_we_d;
      bus_re_q    <= bus_re_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

`ifdef HEX_CMD_TIMEOUT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) tmo_q <= '0;
    else         tmo_q <= tmo_d;
  end
`endif

  assign bus_we    = bus_we_q;
  assign bus_re    = bus_re_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign cmd_err   = cmd_err_q;
  assign rsp_valid = (state_q == RSP);

endmodule
